// File: rtl/pxi_lb_target_ctrl_pkg.sv
// Shared encodings for the PXI local-bus target sequencer: FSM states and LW_R polarity.
package pxi_lb_target_ctrl_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADDR = 2'd1,
      S_WAIT = 2'd2,
      S_DATA = 2'd3
   } lbState_t;

   localparam logic LWR_WRITE = 1'b1;
   localparam logic LWR_READ  = 1'b0;

   localparam int WAIT_W = 4;

endpackage

// File: rtl/pxi_lb_target_ctrl_beat_cnt.sv
// Wait-state down-counter and burst beat counter for the local-bus target sequencer.
module pxi_lb_target_ctrl_beat_cnt
   import pxi_lb_target_ctrl_pkg::*;
#(
   parameter int WAIT_STATES = 2,
   parameter int MAX_BURST   = 256
) (
   input  logic clk,
   input  logic rst,
   input  logic waitLoad,
   input  logic waitDec,
   input  logic beatClr,
   input  logic beatInc,
   output logic waitLast,
   output logic beatMax
);

   localparam int BEAT_W = $clog2(MAX_BURST + 1);
   localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_STATES);

   logic [WAIT_W-1:0] waitCnt;
   logic [BEAT_W-1:0] beatCnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         waitCnt <= '0;
      end else if (waitLoad) begin
         waitCnt <= WAIT_INIT;
      end else if (waitDec && (waitCnt != '0)) begin
         waitCnt <= waitCnt - 1'b1;
      end
   end

   // Counts completed beats of the current burst; cleared whenever the sequencer idles
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         beatCnt <= '0;
      end else if (beatClr) begin
         beatCnt <= '0;
      end else if (beatInc) begin
         beatCnt <= beatCnt + 1'b1;
      end
   end

   assign waitLast = (waitCnt == WAIT_W'(1));
   assign beatMax  = (beatCnt == BEAT_W'(MAX_BURST));

endmodule

// File: rtl/pxi_lb_target_ctrl.sv
// PXI/PCI-bridge local-bus target sequencer: decodes a BASE_ADDR window, inserts wait states,
// drives ready_n and issues one-cycle read/write strobes to the register file.
module pxi_lb_target_ctrl
   import pxi_lb_target_ctrl_pkg::*;
#(
   parameter int          ADDR_W      = 10,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          WAIT_STATES = 2,
   parameter int          MAX_BURST   = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ads,
   input  logic              blast,
   input  logic              lw_r,
   input  logic [29:0]       la,
   input  logic [31:0]       ld_in,
   input  logic [31:0]       rd_data,
   output logic              ready_n,
   output logic [31:0]       ld_out,
   output logic              ld_oe,
   output logic [ADDR_W-1:0] reg_addr,
   output logic              wr_en,
   output logic              rd_en,
   output logic              busy,
   output logic              bus_err
);

   lbState_t state, stateNext;

   logic              txDir, dirNext;
   logic              errNext;
   logic              windowHit;
   logic              beatReady;
   logic              waitLast, beatMax;
   logic              readyNNext, wrEnNext, rdEnNext, ldOeNext, busyNext;
   logic [ADDR_W-1:0] regAddrNext;
   logic [31:0]       ldOutNext;

   // Write data goes straight from the bus pins to the register file
   logic unusedLdIn;
   assign unusedLdIn = ^ld_in;

   assign windowHit = (la[29:ADDR_W] == BASE_ADDR[31:ADDR_W+2]);
   assign beatReady = ((state == S_ADDR) && (WAIT_STATES == 0)) ||
                      ((state == S_WAIT) && waitLast);

   pxi_lb_target_ctrl_beat_cnt #(
      .WAIT_STATES (WAIT_STATES),
      .MAX_BURST   (MAX_BURST)
   ) uBeatCnt (
      .clk      (clk),
      .rst      (rst),
      .waitLoad (state == S_ADDR),
      .waitDec  (state == S_WAIT),
      .beatClr  (state == S_IDLE),
      .beatInc  ((state == S_DATA) && (stateNext == S_ADDR)),
      .waitLast (waitLast),
      .beatMax  (beatMax)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         txDir    <= LWR_READ;
         ready_n  <= 1'b1;
         ld_out   <= '0;
         ld_oe    <= 1'b0;
         reg_addr <= '0;
         wr_en    <= 1'b0;
         rd_en    <= 1'b0;
         busy     <= 1'b0;
         bus_err  <= 1'b0;
      end else begin
         state    <= stateNext;
         txDir    <= dirNext;
         ready_n  <= readyNNext;
         ld_out   <= ldOutNext;
         ld_oe    <= ldOeNext;
         reg_addr <= regAddrNext;
         wr_en    <= wrEnNext;
         rd_en    <= rdEnNext;
         busy     <= busyNext;
         bus_err  <= errNext;
      end
   end

   // A stray ADS outside IDLE aborts the transaction; a burst already at MAX_BURST never gets
   // its next data beat
   always_comb begin
      stateNext = state;
      errNext   = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (!ads && windowHit) stateNext = S_ADDR;
         end
         S_ADDR, S_WAIT: begin
            if (!ads) begin
               errNext   = 1'b1;
               stateNext = S_IDLE;
            end else if (beatReady) begin
               if (beatMax) begin
                  errNext   = 1'b1;
                  stateNext = S_IDLE;
               end else begin
                  stateNext = S_DATA;
               end
            end else if (state == S_ADDR) begin
               stateNext = S_WAIT;
            end
         end
         S_DATA: begin
            if (!ads) begin
               errNext   = 1'b1;
               stateNext = S_IDLE;
            end else if (!blast) begin
               stateNext = S_IDLE;
            end else begin
               stateNext = S_ADDR;
            end
         end
         default: stateNext = S_IDLE;
      endcase
   end

   always_comb begin
      dirNext     = txDir;
      regAddrNext = reg_addr;
      ldOutNext   = ld_out;
      readyNNext  = 1'b1;
      wrEnNext    = 1'b0;
      rdEnNext    = 1'b0;
      if ((state == S_IDLE) && (stateNext == S_ADDR)) begin
         dirNext     = lw_r;
         regAddrNext = la[ADDR_W-1:0];
      end else if ((state == S_DATA) && (stateNext == S_ADDR)) begin
         regAddrNext = reg_addr + 1'b1;
      end
      busyNext = (stateNext != S_IDLE);
      ldOeNext = (stateNext != S_IDLE) && (dirNext == LWR_READ);
      if (stateNext == S_ADDR) begin
         rdEnNext = (dirNext == LWR_READ);
      end
      if (stateNext == S_DATA) begin
         readyNNext = 1'b0;
         wrEnNext   = (dirNext == LWR_WRITE);
         if (dirNext == LWR_READ) ldOutNext = rd_data;
      end
   end

endmodule

// File: tb/tb_pxi_lb_target_ctrl.sv
// Directed testbench for pxi_lb_target_ctrl: a vector table for single beats and window misses,
// then hand-written sequences for bursts, protocol errors and mid-transaction reset.
module tb_pxi_lb_target_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ads = 1'b1;
   logic        blast = 1'b1;
   logic        lw_r = 1'b0;
   logic [29:0] la = '0;
   logic [31:0] ld_in = '0;
   logic [31:0] rd_data = '0;
   logic        ready_n;
   logic [31:0] ld_out;
   logic        ld_oe;
   logic [9:0]  reg_addr;
   logic        wr_en;
   logic        rd_en;
   logic        busy;
   logic        bus_err;

   int testsRun = 0;
   int testsFailed = 0;

   typedef struct {
      logic        ads;
      logic        blast;
      logic        lwR;
      logic [29:0] la;
      logic [31:0] ldIn;
      logic [31:0] rdData;
      logic [47:0] expOut;
   } vec_t;

   vec_t vecs[$];

   pxi_lb_target_ctrl #(
      .ADDR_W      (10),
      .BASE_ADDR   (32'h0000_0000),
      .WAIT_STATES (2),
      .MAX_BURST   (4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .ads      (ads),
      .blast    (blast),
      .lw_r     (lw_r),
      .la       (la),
      .ld_in    (ld_in),
      .rd_data  (rd_data),
      .ready_n  (ready_n),
      .ld_out   (ld_out),
      .ld_oe    (ld_oe),
      .reg_addr (reg_addr),
      .wr_en    (wr_en),
      .rd_en    (rd_en),
      .busy     (busy),
      .bus_err  (bus_err)
   );

   always #5 clk = ~clk;

   function automatic logic [47:0] mkExp(input logic readyN, input logic wrEn, input logic rdEn,
                                         input logic ldOe, input logic busyE, input logic busErr,
                                         input logic [9:0] regAddr, input logic [31:0] ldOut);
      return {readyN, wrEn, rdEn, ldOe, busyE, busErr, regAddr, ldOut};
   endfunction

   function automatic logic [47:0] outVec();
      return {ready_n, wr_en, rd_en, ld_oe, busy, bus_err, reg_addr, ld_out};
   endfunction

   // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge
   task automatic applyStimulus(input logic adsV, input logic blastV, input logic lwV,
                                input logic [29:0] laV, input logic [31:0] ldV,
                                input logic [31:0] rdV);
      @(negedge clk);
      ads     = adsV;
      blast   = blastV;
      lw_r    = lwV;
      la      = laV;
      ld_in   = ldV;
      rd_data = rdV;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [47:0] act, input logic [47:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   initial begin
      int wrCount;
      int errCount;
      logic [9:0] burstAddr [4];

      // Single write at 0x004, single read at 0x010, then out-of-window strobes
      vecs.push_back('{1'b0, 1'b1, 1'b1, 30'h004, 32'hDEADBEEF, 32'h12345678, mkExp(1,0,0,0,1,0,10'h004,32'h0)});
      vecs.push_back('{1'b1, 1'b1, 1'b1, 30'h004, 32'hDEADBEEF, 32'h12345678, mkExp(1,0,0,0,1,0,10'h004,32'h0)});
      vecs.push_back('{1'b1, 1'b1, 1'b1, 30'h004, 32'hDEADBEEF, 32'h12345678, mkExp(1,0,0,0,1,0,10'h004,32'h0)});
      vecs.push_back('{1'b1, 1'b1, 1'b1, 30'h004, 32'hDEADBEEF, 32'h12345678, mkExp(0,1,0,0,1,0,10'h004,32'h0)});
      vecs.push_back('{1'b1, 1'b0, 1'b1, 30'h004, 32'hDEADBEEF, 32'h12345678, mkExp(1,0,0,0,0,0,10'h004,32'h0)});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 30'h010, 32'h0, 32'h12345678, mkExp(1,0,1,1,1,0,10'h010,32'h0)});
      vecs.push_back('{1'b1, 1'b1, 1'b0, 30'h010, 32'h0, 32'h12345678, mkExp(1,0,0,1,1,0,10'h010,32'h0)});
      vecs.push_back('{1'b1, 1'b1, 1'b0, 30'h010, 32'h0, 32'h12345678, mkExp(1,0,0,1,1,0,10'h010,32'h0)});
      vecs.push_back('{1'b1, 1'b1, 1'b0, 30'h010, 32'h0, 32'h12345678, mkExp(0,0,0,1,1,0,10'h010,32'h12345678)});
      vecs.push_back('{1'b1, 1'b0, 1'b0, 30'h010, 32'h0, 32'h12345678, mkExp(1,0,0,0,0,0,10'h010,32'h12345678)});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 30'h400, 32'h0, 32'h0, mkExp(1,0,0,0,0,0,10'h010,32'h12345678)});
      vecs.push_back('{1'b1, 1'b1, 1'b0, 30'h400, 32'h0, 32'h0, mkExp(1,0,0,0,0,0,10'h010,32'h12345678)});
      vecs.push_back('{1'b0, 1'b1, 1'b1, 30'h400, 32'h5, 32'h0, mkExp(1,0,0,0,0,0,10'h010,32'h12345678)});

      #12;
      checkOutput("reset_state", outVec(), mkExp(1,0,0,0,0,0,10'h000,32'h0));
      @(negedge clk);
      rst = 1'b0;

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].ads, vecs[i].blast, vecs[i].lwR, vecs[i].la, vecs[i].ldIn, vecs[i].rdData);
         checkOutput($sformatf("vec%0d", i), outVec(), vecs[i].expOut);
      end

      // Four-beat write burst wrapping past the top of the window
      burstAddr[0] = 10'h3FE;
      burstAddr[1] = 10'h3FF;
      burstAddr[2] = 10'h000;
      burstAddr[3] = 10'h001;
      wrCount = 0;
      applyStimulus(1'b0, 1'b1, 1'b1, 30'h3FE, 32'h11110000, 32'h0);
      for (int c = 1; c <= 16; c++) begin
         applyStimulus(1'b1, (c == 16) ? 1'b0 : 1'b1, 1'b1, 30'h3FE, 32'h11110000 + c, 32'h0);
         if (wr_en) wrCount++;
         if ((c % 4) == 3)
            checkOutput($sformatf("burst_beat%0d", c / 4), 48'({ready_n, wr_en, reg_addr}),
                        48'({1'b0, 1'b1, burstAddr[c / 4]}));
      end
      checkOutput("burst_wr_count", 48'(wrCount), 48'd4);
      checkOutput("burst_idle", 48'({busy, ready_n, wr_en}), 48'(3'b010));

      // BLAST never arrives: fifth beat is refused with a bus error
      wrCount = 0;
      errCount = 0;
      applyStimulus(1'b0, 1'b1, 1'b1, 30'h100, 32'h0, 32'h0);
      for (int c = 1; c <= 20; c++) begin
         applyStimulus(1'b1, 1'b1, 1'b1, 30'h100, 32'h22220000 + c, 32'h0);
         if (wr_en) wrCount++;
         if (bus_err) errCount++;
         if (c == 19)
            checkOutput("maxburst_err", 48'({bus_err, ready_n, wr_en, busy}), 48'(4'b1100));
      end
      checkOutput("maxburst_wr_count", 48'(wrCount), 48'd4);
      checkOutput("maxburst_err_count", 48'(errCount), 48'd1);
      checkOutput("maxburst_addr", 48'(reg_addr), 48'h104);

      // Second ADS during WAIT aborts; a fresh ADS from IDLE is then accepted
      applyStimulus(1'b0, 1'b1, 1'b0, 30'h020, 32'h0, 32'hCAFE0001);
      applyStimulus(1'b1, 1'b1, 1'b0, 30'h020, 32'h0, 32'hCAFE0001);
      applyStimulus(1'b0, 1'b1, 1'b0, 30'h021, 32'h0, 32'hCAFE0001);
      checkOutput("ads_wait_err", 48'({bus_err, busy, ld_oe, rd_en, ready_n}), 48'(5'b10001));
      checkOutput("ads_wait_addr", 48'(reg_addr), 48'h020);
      applyStimulus(1'b0, 1'b1, 1'b0, 30'h021, 32'h0, 32'hCAFE0001);
      checkOutput("ads_after_err", 48'({bus_err, busy, rd_en, ld_oe, reg_addr}),
                  48'({1'b0, 1'b1, 1'b1, 1'b1, 10'h021}));
      for (int c = 1; c <= 3; c++)
         applyStimulus(1'b1, 1'b1, 1'b0, 30'h021, 32'h0, 32'hCAFE0001);
      checkOutput("ads_retry_data", 48'({ready_n, ld_out}), 48'({1'b0, 32'hCAFE0001}));
      applyStimulus(1'b1, 1'b0, 1'b0, 30'h021, 32'h0, 32'hCAFE0001);
      checkOutput("ads_retry_idle", 48'({busy, ready_n, ld_oe}), 48'(3'b010));

      // Reset lands in the middle of the second data beat of a read burst
      applyStimulus(1'b0, 1'b1, 1'b0, 30'h050, 32'h0, 32'hA5A50001);
      for (int c = 1; c <= 7; c++)
         applyStimulus(1'b1, 1'b1, 1'b0, 30'h050, 32'h0, 32'hA5A50001);
      checkOutput("rst_pre", 48'({ready_n, ld_oe, reg_addr, ld_out}),
                  48'({1'b0, 1'b1, 10'h051, 32'hA5A50001}));
      #2;
      rst = 1'b1;
      #1;
      checkOutput("rst_mid", outVec(), mkExp(1,0,0,0,0,0,10'h000,32'h0));
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(1'b0, 1'b1, 1'b0, 30'h007, 32'h0, 32'h0BADF00D);
      checkOutput("rst_readdr", 48'({busy, rd_en, reg_addr}), 48'({1'b1, 1'b1, 10'h007}));
      for (int c = 1; c <= 3; c++)
         applyStimulus(1'b1, 1'b1, 1'b0, 30'h007, 32'h0, 32'h0BADF00D);
      checkOutput("rst_redata", 48'({ready_n, ld_oe, ld_out}), 48'({1'b0, 1'b1, 32'h0BADF00D}));
      applyStimulus(1'b1, 1'b0, 1'b0, 30'h007, 32'h0, 32'h0BADF00D);
      checkOutput("rst_reidle", 48'({busy, ready_n, bus_err}), 48'(3'b010));

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
